// File: rtl/flood_pkg.sv
// Shared level constants, level type and controller state encoding for the
// flood monitor level source.
package flood_pkg;

  typedef logic [4:0] lvl_t;

  typedef enum logic [1:0] {
    IDLE,
    PUMP,
    HOLD
  } state_t;

  localparam lvl_t LVL_MAX   = 5'd28;
  localparam lvl_t LVL_ALARM = 5'd24;
  localparam lvl_t LVL_LOW   = 5'd10;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-count debounce and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce
  import flood_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             db_p2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      db_p2   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // The counter only runs while the sample disagrees with the accepted
      // level, so any agreeing sample restarts the stability window.
      if (sync_p1 != db_p2) begin
        if (cnt == CNT_TERM) begin
          db_p2 <= sync_p1;
          cnt   <= '0;
          press <= sync_p1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pump_drain_ctrl.sv
// Water-level register for the flood monitor: tracks SW in IDLE, drains in
// 0.5 m steps while pumping. Optional macro AUTO_START_EN starts the pump
// automatically at the alarm level.
module pump_drain_ctrl
  import flood_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 1_000_000,
  parameter int SLOW_STEP_CYC = 50_000_000,
  parameter int FAST_STEP_CYC = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] SW,
  input  logic       btn0,
  input  logic       btn7,
  output logic [3:0] water_level_int,
  output logic       water_level_frac,
  output logic       pump_on,
  output logic       pump_fast,
  output logic       drain_done
);

  localparam int STEP_MAX = (SLOW_STEP_CYC > FAST_STEP_CYC) ? SLOW_STEP_CYC : FAST_STEP_CYC;
  localparam int CNT_W    = $clog2(STEP_MAX + 1);
  localparam logic [CNT_W-1:0] SLOW_TERM = CNT_W'(SLOW_STEP_CYC - 1);
  localparam logic [CNT_W-1:0] FAST_TERM = CNT_W'(FAST_STEP_CYC - 1);
  localparam lvl_t LVL_LOW_P1 = LVL_LOW + 5'd1;

  logic [4:0]       sw_p0;
  logic [4:0]       sw_p1;
  logic             btn0_press;
  logic             btn7_press;

  state_t           state, state_n;
  lvl_t             lvl, lvl_n;
  lvl_t             sw_cap, sw_cap_n;
  logic [CNT_W-1:0] step_cnt, step_cnt_n;
  logic [CNT_W-1:0] step_term;
  logic             fast, fast_n;
  logic             pump_q, pump_n;
  logic             done, done_n;
`ifdef AUTO_START_EN
  logic             stop_hold, stop_hold_n;
`endif

  function automatic lvl_t clamp_lvl(input logic [4:0] req);
    return (req > LVL_MAX) ? LVL_MAX : lvl_t'(req);
  endfunction

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_btn0 (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn0),
    .press (btn0_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_btn7 (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn7),
    .press (btn7_press)
  );

  // Stage p0/p1: switch synchronizer feeding the level register
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= SW;
      sw_p1 <= sw_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      lvl      <= '0;
      sw_cap   <= '0;
      step_cnt <= '0;
      fast     <= 1'b0;
      pump_q   <= 1'b0;
      done     <= 1'b0;
`ifdef AUTO_START_EN
      stop_hold <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      lvl      <= lvl_n;
      sw_cap   <= sw_cap_n;
      step_cnt <= step_cnt_n;
      fast     <= fast_n;
      pump_q   <= pump_n;
      done     <= done_n;
`ifdef AUTO_START_EN
      stop_hold <= stop_hold_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    lvl_n      = lvl;
    sw_cap_n   = sw_cap;
    step_cnt_n = step_cnt;
    fast_n     = fast;
    done_n     = 1'b0;
`ifdef AUTO_START_EN
    stop_hold_n = stop_hold;
`endif
    step_term  = fast ? FAST_TERM : SLOW_TERM;

    unique case (state)
      IDLE: begin
        lvl_n = clamp_lvl(sw_p1);
`ifdef AUTO_START_EN
        // A manual stop stays latched until the level falls below alarm.
        if (lvl < LVL_ALARM) stop_hold_n = 1'b0;
        if (!stop_hold && lvl >= LVL_ALARM) begin
`else
        if (btn0_press && lvl >= LVL_ALARM) begin
`endif
          state_n    = PUMP;
          step_cnt_n = '0;
          fast_n     = 1'b0;
        end
      end
      PUMP: begin
        // Priority: stop, then speed toggle, then the drain step.
        if (btn0_press) begin
          state_n    = IDLE;
          fast_n     = 1'b0;
          step_cnt_n = '0;
`ifdef AUTO_START_EN
          stop_hold_n = 1'b1;
`endif
        end else if (btn7_press) begin
          fast_n     = ~fast;
          step_cnt_n = '0;
        end else if (step_cnt == step_term) begin
          step_cnt_n = '0;
          lvl_n      = lvl - 5'd1;
          if (lvl == LVL_LOW_P1) begin
            state_n  = HOLD;
            fast_n   = 1'b0;
            done_n   = 1'b1;
            sw_cap_n = sw_p1;
          end
        end else begin
          step_cnt_n = step_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (sw_p1 != sw_cap) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    pump_n = (state_n == PUMP);
  end

  assign water_level_int  = lvl[4:1];
  assign water_level_frac = lvl[0];
  assign pump_on          = pump_q;
  assign pump_fast        = fast;
  assign drain_done       = done;

endmodule

// File: doc/pump_drain_ctrl.md
Name: pump_drain_ctrl

Overview:
- Upstream water-level source for the flood monitor. It replaces direct switch decoding with a level register that can be drained by the pump.
- In IDLE the level tracks the SW4..SW0 switches. A debounced btn0 press starts the pump, which lowers the level in 0.5 m steps; btn7 toggles drain speed.
- Outputs feed the dot-matrix, seven-segment and buzzer stages, and pump status drives the top-level display mux.

Parameters:
- DEBOUNCE_CYC, 1_000_000: stable cycles (20 ms at 50 MHz) needed to accept a button level.
- SLOW_STEP_CYC, 50_000_000: cycles per 0.5 m step at slow speed.
- FAST_STEP_CYC, 25_000_000: cycles per 0.5 m step at fast speed.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted when rst=0, sampled on posedge clk)
- SW  in  5  requested level in half-metres; values above 28 clamp to 28
- btn0  in  1  raw pump start/stop button, active-high
- btn7  in  1  raw speed toggle button, active-high
- water_level_int  out  4  integer metres, 0..14
- water_level_frac  out  1  1 = +0.5 m
- pump_on  out  1  pump running
- pump_fast  out  1  fast drain selected
- drain_done  out  1  one-cycle pulse when the low mark is reached

Behaviour:
- Reset (rst=0 at posedge clk):
  - lvl=0, state=IDLE, all outputs 0.
  - Debouncers, synchronizers and step counter cleared.
- Input conditioning:
  - SW, btn0 and btn7 pass through 2-flop synchronizers.
  - Each button is debounced: the output changes only after DEBOUNCE_CYC consecutive equal samples.
  - A "press" is a one-cycle rising edge of the debounced output.
- Level and outputs:
  - Internal lvl is 5 bits, in half-metres.
  - water_level_int = lvl[4:1]; water_level_frac = lvl[0]. All outputs are registered.
  - In IDLE, lvl <= min(SW_sync, 28) every cycle. Latency from an SW pin change to the output is 3 cycles.
- Level constants: LVL_MAX=28, LVL_ALARM=24 (12 m), LVL_LOW=10 (5 m).
- FSM states: IDLE, PUMP, HOLD.
  - IDLE -> PUMP on a btn0 press when lvl >= LVL_ALARM.
    - On entry: pump_on=1, pump_fast=0, step counter=0.
    - A btn0 press with lvl < 24 is ignored.
  - PUMP:
    - The step counter increments each cycle.
    - At terminal count (SLOW_STEP_CYC-1, or FAST_STEP_CYC-1 if pump_fast): lvl <= lvl-1 and the counter returns to 0.
    - A btn7 press toggles pump_fast and restarts the counter at 0.
    - SW is ignored while in PUMP.
  - PUMP -> IDLE on a btn0 press: pump_on=0, pump_fast=0. From the next cycle lvl resumes tracking SW.
  - PUMP -> HOLD when a step makes lvl == LVL_LOW.
    - drain_done=1 for exactly the cycle of entry; pump_on=0, pump_fast=0.
    - lvl is frozen.
  - HOLD -> IDLE when SW_sync differs from the value captured on HOLD entry. Button presses are ignored in HOLD.
- Simultaneous events:
  - btn0 press and step on the same cycle: stop wins, the step is discarded.
  - btn0 and btn7 press together in PUMP: stop wins.
  - btn7 press and terminal count together: the toggle wins and no step occurs.
- Reset mid-PUMP: immediate return to reset values. No drain_done pulse.

Optional Feature:
- Macro: AUTO_START_EN.
- Defined:
  - IDLE enters PUMP automatically on the first cycle lvl >= LVL_ALARM, without a btn0 press.
  - A btn0 press in PUMP still stops the pump. The stop then holds in IDLE until lvl drops below LVL_ALARM, preventing an immediate restart.
- Undefined: the pump starts only on a btn0 press.

Decomposition:
- Package flood_pkg:
  - LVL_MAX=28, LVL_ALARM=24, LVL_LOW=10 (5-bit half-metre constants).
  - State enum {IDLE, PUMP, HOLD}.
  - Half-metre level typedef (5 bits).
- Sub-module btn_debounce: synchronizer, debounce counter and rising-edge press output. Instantiated twice (btn0, btn7).

Test Plan (DEBOUNCE_CYC=4, SLOW_STEP_CYC=8, FAST_STEP_CYC=4):
- Reset then SW=5'd25 -> after 3 cycles water_level_int=12, frac=1, pump_on=0.
- SW=5'd31 -> outputs clamp to 14, frac=0.
- SW=20, btn0 held 6 cycles -> no state change, pump_on stays 0.
- SW=26, btn0 press -> pump_on=1. Level 26->25 after 8 cycles. btn7 press -> pump_fast=1 and subsequent steps every 4 cycles. Drain continues to lvl=10, drain_done pulses once, pump_on=0, frac=0, int=5. SW change -> IDLE, tracks new SW.
- PUMP at lvl=24, btn0 press on a terminal-count cycle -> lvl stays 24, IDLE, pump_on=0. rst=0 mid-PUMP -> all outputs 0 next cycle.
- AUTO_START_EN: SW=24 -> pump_on=1 without any button press. btn0 press -> pump stops and stays stopped with SW=24; setting SW=23 then SW=24 restarts it.
